// File: rtl/monitor_pio_pkg.sv
// Shared definitions for the monitor PIO blocks: register map, edge-type
// selection and the common register reset value.
package monitor_pio_pkg;

  localparam logic [1:0]  PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0]  PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0]  PIO_ADDR_RSVD    = 2'd2;
  localparam logic [1:0]  PIO_ADDR_EDGECAP = 2'd3;
  localparam logic [31:0] PIO_RESET_VAL    = 32'h0000_0000;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Single-bit edge detector shared by every input PIO flavour.
  function automatic logic edge_bit(edge_type_e kind, logic cur, logic prv);
    logic hit;
    case (kind)
      EDGE_RISE: hit = cur & ~prv;
      EDGE_FALL: hit = ~cur & prv;
      EDGE_ANY:  hit = cur ^ prv;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/monitor_sync2.sv
// WIDTH-parameterized two-flop synchronizer with async active-low reset,
// shared by the monitor input blocks.
module monitor_sync2
  import monitor_pio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back capture stages for the asynchronous input bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= PIO_RESET_VAL[WIDTH-1:0];
      q    <= PIO_RESET_VAL[WIDTH-1:0];
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/monitor_pio_in.sv
// Avalon-MM input PIO for the monitor: synchronized DATA, plus optional
// IRQMASK/EDGECAP/irq built only when MONITOR_PIO_IN_IRQ_EN is defined.
module monitor_pio_in
  import monitor_pio_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter edge_type_e EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic             wr_en;
  logic             unused_bus;

  assign wr_en      = chipselect & ~write_n;
  assign unused_bus = ^{wr_en, writedata};

  monitor_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (data)
  );

`ifdef MONITOR_PIO_IN_IRQ_EN
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic [1:0]       settle;
  logic             armed;

  // Edges are ignored until the synchronizer has flushed its reset contents.
  assign armed = (settle == 2'd3);

  // Previous synchronized sample and the saturating settle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= PIO_RESET_VAL[WIDTH-1:0];
      settle <= 2'd0;
    end else begin
      prev <= data;
      if (!armed) begin
        settle <= settle + 2'd1;
      end else begin
        settle <= settle;
      end
    end
  end

  // Per-bit edge set and write-1-to-clear strobes.
  always_comb begin
    set = '0;
    clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set[i] = armed & edge_bit(EDGE_TYPE, data[i], prev[i]);
    end
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      clr = writedata[WIDTH-1:0];
    end else begin
      clr = '0;
    end
  end

  // Interrupt mask and edge-capture registers; a set wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= PIO_RESET_VAL[WIDTH-1:0];
      cap  <= PIO_RESET_VAL[WIDTH-1:0];
    end else begin
      if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
        mask <= writedata[WIDTH-1:0];
      end else begin
        mask <= mask;
      end
      cap <= set | (cap & ~clr);
    end
  end

  assign irq = |(cap & mask);
`else
  assign mask = '0;
  assign cap  = '0;
  assign irq  = 1'b0;
`endif

  // Zero-wait-state read mux, zero-extended above WIDTH.
  always_comb begin
    readdata = PIO_RESET_VAL;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = data;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = mask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = cap;
      default:          readdata = PIO_RESET_VAL;
    endcase
  end

endmodule
